fpga_config_loader: RTL and testbench
=====================================

// Module: fpga_config_loader
// PURPOSE
//   Sequences the FPGA fabric configuration image into the LUT and switch-box
//   configuration registers over a valid/ready word stream, in the standard
//   42-word image order: LUT truth tables, switch-box words, LUT flop-selects.
//   Holds the fabric disabled until the full image is written. It replaces
//   hierarchical memory pokes with a synthesizable load path.
// PARAMETERS
//   NUM_LUT  11  number of LUT instances (lt1..ltN -> index 0..NUM_LUT-1)
//   NUM_SB   20  number of switch-box instances (sb1..sbN -> index 0..NUM_SB-1)
//   WORD_W   32  configuration word width
// PORTS
//   clock       in   1            fabric/config clock, rising edge
//   reset_n     in   1            asynchronous, active-low reset
//   start       in   1            1-cycle pulse: begin (or restart) load
//   cfg_valid   in   1            cfg_word valid
//   cfg_word    in   WORD_W       configuration word
//   cfg_ready   out  1            loader accepts cfg_word this cycle
//   lut_we      out  NUM_LUT      one-hot truth-table write strobe
//   lut_ff_we   out  NUM_LUT      one-hot flop-select write strobe
//   lut_ff_sel  out  1            flop-select value for lut_ff_we
//   sb_we       out  NUM_SB       one-hot switch-box write strobe
//   cfg_wdata   out  WORD_W       data for lut_we / sb_we
//   word_idx    out  6            index of next expected word (0..41)
//   busy        out  1            load in progress
//   done        out  1            full image written, sticky until start
//   fabric_en   out  1            fabric clock-enable; high only when done
// BEHAVIOUR
//   - Reset (async, reset_n=0): state IDLE; all strobes 0, cfg_wdata 0,
//     lut_ff_sel 0, word_idx 0, cfg_ready/busy/done/fabric_en 0.
//   - States: IDLE -> (start) LUT -> SB -> FF -> DONE -> (start) LUT.
//   - Word accepted on cycle with cfg_valid & cfg_ready; cfg_ready = 1 in
//     LUT/SB/FF only. One word per cycle max; gaps in cfg_valid allowed.
//   - Latency: strobe + data registered, asserted exactly 1 cycle after
//     acceptance, high for 1 cycle; all other strobes 0 that cycle.
//   - LUT (idx 0..NUM_LUT-1): lut_we[idx]=1, cfg_wdata=word; simultaneously
//     lut_ff_we[idx]=1 with lut_ff_sel=0 (flop bypassed until FF phase).
//   - SB (idx NUM_LUT..NUM_LUT+NUM_SB-1): sb_we[idx-NUM_LUT]=1, cfg_wdata=word.
//   - FF (idx NUM_LUT+NUM_SB..2*NUM_LUT+NUM_SB-1): lut_ff_we[k]=1,
//     lut_ff_sel=word[WORD_W-1] (MSB); other bits ignored; cfg_wdata unchanged.
//   - word_idx increments per accepted word; phase transitions on the last
//     word of each phase; after idx 41 -> DONE, word_idx holds 42? no: wraps to
//     0; busy=0, done=1, fabric_en=1 in the cycle the final strobe is issued.
//   - busy=1 in LUT/SB/FF. fabric_en=0 whenever state != DONE.
//   - start in any state (incl. mid-load or DONE): word_idx<=0, state LUT,
//     done/fabric_en<=0 next cycle; a word presented with start the same cycle
//     is NOT accepted (cfg_ready forced 0 that cycle).
//   - start while IDLE/DONE with cfg_valid=0: simply waits in LUT phase.
//   - cfg_valid outside load states: ignored, no strobes.
//   - reset_n low mid-load: immediate return to reset values; partial config
//     in fabric is left as-is, fabric_en stays 0.
// TESTING
//   - Reset: reset_n=0 mid-stream -> all outputs 0 asynchronously, word_idx 0.
//   - Full load, back-to-back valid, 42 words -> 42 single strobes in order,
//     word 5=32'hA5A5_0001 gives lut_we=1<<5, lut_ff_we=1<<5, sel 0; done at cycle 43.
//   - SB word idx 11=32'h1234_5678 -> sb_we=1<<0, cfg_wdata=32'h1234_5678.
//   - FF word idx 41=32'h8000_0000 -> lut_ff_we=1<<10, lut_ff_sel=1; idx 31=0 -> sel 0.
//   - Valid toggling 1/0 each cycle -> same strobe sequence, no dup/skip words.
//   - start at word_idx 20 -> idx resets to 0, next word writes lut_we[0];
//     start in DONE -> fabric_en drops next cycle, done cleared.

Source files
------------

// File: rtl/fpga_config_loader.sv
// fpga_config_loader
//   Streams the fabric configuration image into the LUT and switch-box
//   configuration registers. The image has 2*NUM_LUT+NUM_SB words in this
//   order: LUT truth tables, switch-box words, LUT flop-selects. The fabric
//   clock-enable stays low until the last word has been written.
//
// Ports
//   clock      in   rising-edge config/fabric clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle pulse that begins (or restarts) a load
//   cfg_valid  in   cfg_word is valid
//   cfg_word   in   configuration word
//   cfg_ready  out  a word is accepted this cycle when cfg_valid is also high
//   lut_we     out  one-hot LUT truth-table write strobe
//   lut_ff_we  out  one-hot LUT flop-select write strobe
//   lut_ff_sel out  flop-select value that goes with lut_ff_we
//   sb_we      out  one-hot switch-box write strobe
//   cfg_wdata  out  write data for lut_we / sb_we
//   word_idx   out  index of the next expected image word
//   busy       out  load in progress
//   done       out  full image written; held until the next start
//   fabric_en  out  fabric clock-enable, high only once the image is complete
module fpga_config_loader #(
  parameter int NUM_LUT = 11,
  parameter int NUM_SB  = 20,
  parameter int WORD_W  = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               cfg_valid,
  input  logic [WORD_W-1:0]  cfg_word,
  output logic               cfg_ready,
  output logic [NUM_LUT-1:0] lut_we,
  output logic [NUM_LUT-1:0] lut_ff_we,
  output logic               lut_ff_sel,
  output logic [NUM_SB-1:0]  sb_we,
  output logic [WORD_W-1:0]  cfg_wdata,
  output logic [5:0]         word_idx,
  output logic               busy,
  output logic               done,
  output logic               fabric_en
);

  typedef enum logic [2:0] {IDLE, LUT, SB, FF, DONE} state_t;

  localparam logic [5:0] LUT_LAST = 6'(NUM_LUT - 1);
  localparam logic [5:0] SB_FIRST = 6'(NUM_LUT);
  localparam logic [5:0] SB_LAST  = 6'(NUM_LUT + NUM_SB - 1);
  localparam logic [5:0] FF_FIRST = 6'(NUM_LUT + NUM_SB);
  localparam logic [5:0] FF_LAST  = 6'(2 * NUM_LUT + NUM_SB - 1);

  localparam logic [NUM_LUT-1:0] LUT_ONE = {{(NUM_LUT-1){1'b0}}, 1'b1};
  localparam logic [NUM_SB-1:0]  SB_ONE  = {{(NUM_SB-1){1'b0}}, 1'b1};

  state_t     state;
  logic       accept;
  logic [5:0] sb_off;
  logic [5:0] ff_off;

  // busy is high exactly in LUT/SB/FF; start wins over a word offered in the
  // same cycle so a restart never swallows the first word of the new image.
  assign cfg_ready = busy & ~start;
  assign accept    = cfg_valid & cfg_ready;
  assign sb_off    = word_idx - SB_FIRST;
  assign ff_off    = word_idx - FF_FIRST;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lut_we     <= '0;
      lut_ff_we  <= '0;
      lut_ff_sel <= 1'b0;
      sb_we      <= '0;
      cfg_wdata  <= '0;
      word_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fabric_en  <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses issued one cycle after acceptance.
      lut_we    <= '0;
      lut_ff_we <= '0;
      sb_we     <= '0;
      if (start) begin
        state     <= LUT;
        word_idx  <= '0;
        busy      <= 1'b1;
        done      <= 1'b0;
        fabric_en <= 1'b0;
      end else if (accept) begin
        word_idx <= word_idx + 6'd1;
        case (state)
          LUT: begin
            // Flop is bypassed until the FF phase writes the real select.
            lut_we     <= LUT_ONE << word_idx;
            lut_ff_we  <= LUT_ONE << word_idx;
            lut_ff_sel <= 1'b0;
            cfg_wdata  <= cfg_word;
            if (word_idx == LUT_LAST) state <= SB;
          end
          SB: begin
            sb_we     <= SB_ONE << sb_off;
            cfg_wdata <= cfg_word;
            if (word_idx == SB_LAST) state <= FF;
          end
          FF: begin
            // Only the MSB carries the flop select; cfg_wdata is left alone.
            lut_ff_we  <= LUT_ONE << ff_off;
            lut_ff_sel <= cfg_word[WORD_W-1];
            if (word_idx == FF_LAST) begin
              state     <= DONE;
              word_idx  <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              fabric_en <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
module tb_fpga_config_loader;

  localparam int NL = 11;
  localparam int NS = 20;
  localparam int NW = 2 * NL + NS;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          cfg_valid;
  logic [31:0]   cfg_word;
  logic          cfg_ready;
  logic [NL-1:0] lut_we;
  logic [NL-1:0] lut_ff_we;
  logic          lut_ff_sel;
  logic [NS-1:0] sb_we;
  logic [31:0]   cfg_wdata;
  logic [5:0]    word_idx;
  logic          busy;
  logic          done;
  logic          fabric_en;

  fpga_config_loader #(.NUM_LUT(NL), .NUM_SB(NS), .WORD_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .cfg_valid  (cfg_valid),
    .cfg_word   (cfg_word),
    .cfg_ready  (cfg_ready),
    .lut_we     (lut_we),
    .lut_ff_we  (lut_ff_we),
    .lut_ff_sel (lut_ff_sel),
    .sb_we      (sb_we),
    .cfg_wdata  (cfg_wdata),
    .word_idx   (word_idx),
    .busy       (busy),
    .done       (done),
    .fabric_en  (fabric_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cyc;
    logic [NL-1:0] lut_we;
    logic [NL-1:0] lut_ff_we;
    logic          sel;
    logic [NS-1:0] sb_we;
    logic [31:0]   wdata;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          m_idx = 0;
  logic [31:0] m_wdata = '0;
  logic        m_sel = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor: every non-zero strobe cycle must match the next queued write.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset_n && (lut_we != 0 || lut_ff_we != 0 || sb_we != 0)) begin
      if (q.size() == 0) begin
        chk("strobe_unexpected", {lut_we, lut_ff_we, sb_we}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
        chk("lut_we", 64'(lut_we), 64'(e.lut_we));
        chk("lut_ff_we", 64'(lut_ff_we), 64'(e.lut_ff_we));
        chk("sb_we", 64'(sb_we), 64'(e.sb_we));
        chk("cfg_wdata", 64'(cfg_wdata), 64'(e.wdata));
        if (e.lut_ff_we != 0) chk("lut_ff_sel", 64'(lut_ff_sel), 64'(e.sel));
      end
    end
  end

  function automatic logic [31:0] word_for(input int i);
    case (i)
      5:       return 32'hA5A5_0001;
      11:      return 32'h1234_5678;
      31:      return 32'h0000_0000;
      41:      return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; offers one word, queues its expected write, returns
  // at the following negedge.
  task automatic send(input logic [31:0] w);
    exp_t e;
    cfg_valid = 1'b1;
    cfg_word  = w;
    #1;
    chk("ready_in_load", 64'(cfg_ready), 64'd1);
    chk("word_idx", 64'(word_idx), 64'(m_idx));
    chk("busy_in_load", 64'(busy), 64'd1);
    chk("done_in_load", 64'(done), 64'd0);
    e.cyc       = cyc + 1;
    e.lut_we    = '0;
    e.lut_ff_we = '0;
    e.sb_we     = '0;
    if (m_idx < NL) begin
      e.lut_we    = NL'(1) << m_idx;
      e.lut_ff_we = NL'(1) << m_idx;
      m_sel       = 1'b0;
      m_wdata     = w;
    end else if (m_idx < NL + NS) begin
      e.sb_we = NS'(1) << (m_idx - NL);
      m_wdata = w;
    end else begin
      e.lut_ff_we = NL'(1) << (m_idx - NL - NS);
      m_sel       = w[31];
    end
    e.sel   = m_sel;
    e.wdata = m_wdata;
    q.push_back(e);
    m_idx = (m_idx == NW - 1) ? 0 : m_idx + 1;
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic with_valid);
    start     = 1'b1;
    cfg_valid = with_valid;
    cfg_word  = 32'hDEAD_BEEF;
    #1;
    chk("ready_during_start", 64'(cfg_ready), 64'd0);
    @(negedge clock);
    start     = 1'b0;
    cfg_valid = 1'b0;
    m_idx     = 0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_fabric_en", 64'(fabric_en), 64'd0);
    chk("start_word_idx", 64'(word_idx), 64'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_strobes", {lut_we, lut_ff_we, sb_we}, 64'd0);
    chk("rst_wdata", 64'(cfg_wdata), 64'd0);
    chk("rst_sel", 64'(lut_ff_sel), 64'd0);
    chk("rst_word_idx", 64'(word_idx), 64'd0);
    chk("rst_ctrl", {60'd0, cfg_ready, busy, done, fabric_en}, 64'd0);
  endtask

  task automatic chk_done_state();
    chk("done", 64'(done), 64'd1);
    chk("fabric_en", 64'(fabric_en), 64'd1);
    chk("busy_done", 64'(busy), 64'd0);
    chk("word_idx_wrap", 64'(word_idx), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_word  = '0;
    repeat (3) @(negedge clock);
    chk_reset_vals();
    reset_n = 1'b1;
    @(negedge clock);

    // Words offered while idle are ignored.
    cfg_valid = 1'b1;
    cfg_word  = 32'h5555_AAAA;
    #1;
    chk("ready_idle", 64'(cfg_ready), 64'd0);
    repeat (2) @(negedge clock);
    cfg_valid = 1'b0;
    chk("busy_idle", 64'(busy), 64'd0);

    // Full load with back-to-back words.
    pulse_start(1'b0);
    for (int i = 0; i < NW; i++) begin
      send(word_for(i));
      if (i < NW - 1) chk("fabric_en_early", 64'(fabric_en), 64'd0);
    end
    chk_done_state();

    // Words offered in DONE are ignored.
    cfg_valid = 1'b1;
    #1;
    chk("ready_done", 64'(cfg_ready), 64'd0);
    repeat (2) @(negedge clock);
    cfg_valid = 1'b0;
    chk("done_sticky", 64'(done), 64'd1);

    // Restart from DONE with a word offered alongside start.
    pulse_start(1'b1);
    repeat (2) @(negedge clock);
    chk("wait_in_lut_idx", 64'(word_idx), 64'd0);

    // Gapped load: valid toggles every cycle.
    for (int i = 0; i < NW; i++) begin
      send(word_for(i));
      @(negedge clock);
    end
    chk_done_state();

    // Restart in the middle of a load at word 20.
    pulse_start(1'b0);
    for (int i = 0; i < 20; i++) send(word_for(i));
    chk("idx_before_restart", 64'(word_idx), 64'd20);
    pulse_start(1'b1);
    for (int i = 0; i < NW; i++) send(word_for(i));
    chk_done_state();

    // Asynchronous reset in the middle of a load.
    pulse_start(1'b0);
    for (int i = 0; i < 15; i++) send(word_for(i));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_after_reset", {62'd0, busy, cfg_ready}, 64'd0);

    repeat (4) @(negedge clock);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
